turn_sequencer_slave: RTL and testbench

Game-level controller for the slave board. It alternates turns between remote player P1 (master board) and local player P2, and drives cur_game_state, start_guess and clear_guess into the guess handler. After each guess it scores the 5x5 circle map for completed lines, and it transmits the local player's selected number and any win notification over the interboard link. It sits between the menu/top FSM, the guess handler and the interboard transmitter.

---
 rtl/turn_sequencer_slave.sv | 177 +++++++++++++++++
 tb/tb_turn_sequencer_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer_slave.sv
// Slave-board game sequencer: alternates P1 (remote) and P2 (local) turns,
// scores the 5x5 circle map after every guess and reports results over the link.
module turn_sequencer_slave #(
   parameter int WIN_LINES = 5,
   parameter bit P1_FIRST  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interboard_rst,
   input  logic        start_game,
   input  logic        interboard_en,
   input  logic [2:0]  interboard_msg_type,
   input  logic        guess_done,
   input  logic [4:0]  guess_number,
   input  logic [24:0] circle,
   output logic [3:0]  cur_game_state,
   output logic        start_guess,
   output logic        clear_guess,
   output logic        tx_en,
   output logic [2:0]  tx_msg_type,
   output logic [4:0]  tx_number,
   output logic [3:0]  line_count,
   output logic [4:0]  turn_count,
   output logic [1:0]  game_result
);

   localparam logic [2:0] MSG_SEL_NUM   = 3'd1;
   localparam logic [2:0] MSG_STATE_WIN = 3'd4;
   localparam logic [3:0] WIN_LINES_L   = 4'(WIN_LINES);

   // GAME_DECIDE is the internal second half of the scoring step; it is
   // reported as GAME_CHECK so external state codes stay as published.
   typedef enum logic [3:0] {
      GAME_IDLE          = 4'd0,
      GAME_INIT          = 4'd1,
      GAME_WAIT_P1_GUESS = 4'd2,
      GAME_P2_GUESS      = 4'd3,
      GAME_DECIDE        = 4'd4,
      GAME_CHECK         = 4'd5,
      GAME_WIN           = 4'd6,
      GAME_LOSE          = 4'd7,
      GAME_DRAW          = 4'd8
   } game_state_t;

   game_state_t state;
   logic        p2_last;

   function automatic logic [3:0] count_lines(input logic [24:0] c);
      logic [3:0] n;
      logic       row_full;
      logic       col_full;
      logic       diag_main;
      logic       diag_anti;
      n         = 4'd0;
      diag_main = 1'b1;
      diag_anti = 1'b1;
      for (int i = 0; i < 5; i++) begin
         row_full = 1'b1;
         col_full = 1'b1;
         for (int j = 0; j < 5; j++) begin
            row_full = row_full & c[i*5+j];
            col_full = col_full & c[j*5+i];
         end
         n         = n + {3'd0, row_full} + {3'd0, col_full};
         diag_main = diag_main & c[i*6];
         diag_anti = diag_anti & c[i*4+4];
      end
      n = n + {3'd0, diag_main} + {3'd0, diag_anti};
      return n;
   endfunction

   // Pulse outputs default low every cycle; each transition raises what it needs.
   always_ff @(posedge clk) begin
      if (rst || interboard_rst) begin
         state          <= GAME_IDLE;
         cur_game_state <= GAME_IDLE;
         p2_last        <= 1'b0;
         start_guess    <= 1'b0;
         clear_guess    <= 1'b0;
         tx_en          <= 1'b0;
         tx_msg_type    <= 3'd0;
         tx_number      <= 5'd0;
         line_count     <= 4'd0;
         turn_count     <= 5'd0;
         game_result    <= 2'd0;
      end else begin
         start_guess <= 1'b0;
         clear_guess <= 1'b0;
         tx_en       <= 1'b0;
         tx_msg_type <= 3'd0;
         tx_number   <= 5'd0;
         case (state)
            GAME_IDLE: begin
               if (start_game) begin
                  state          <= GAME_INIT;
                  cur_game_state <= GAME_INIT;
                  clear_guess    <= 1'b1;
               end
            end
            GAME_INIT: begin
               turn_count  <= 5'd0;
               line_count  <= 4'd0;
               game_result <= 2'd0;
               start_guess <= 1'b1;
               if (P1_FIRST) begin
                  state          <= GAME_WAIT_P1_GUESS;
                  cur_game_state <= GAME_WAIT_P1_GUESS;
               end else begin
                  state          <= GAME_P2_GUESS;
                  cur_game_state <= GAME_P2_GUESS;
               end
            end
            GAME_WAIT_P1_GUESS: begin
               if (interboard_en && interboard_msg_type == MSG_STATE_WIN) begin
                  state          <= GAME_LOSE;
                  cur_game_state <= GAME_LOSE;
                  game_result    <= 2'd2;
               end else if (guess_done) begin
                  state          <= GAME_CHECK;
                  cur_game_state <= GAME_CHECK;
                  p2_last        <= 1'b0;
               end
            end
            GAME_P2_GUESS: begin
               if (guess_done) begin
                  state          <= GAME_CHECK;
                  cur_game_state <= GAME_CHECK;
                  p2_last        <= 1'b1;
                  tx_en          <= 1'b1;
                  tx_msg_type    <= MSG_SEL_NUM;
                  tx_number      <= guess_number;
               end
            end
            GAME_CHECK: begin
               line_count     <= count_lines(circle);
               turn_count     <= turn_count + 5'd1;
               state          <= GAME_DECIDE;
               cur_game_state <= GAME_CHECK;
            end
            // Decision uses the freshly registered line and turn counts.
            GAME_DECIDE: begin
               if (line_count >= WIN_LINES_L) begin
                  state          <= GAME_WIN;
                  cur_game_state <= GAME_WIN;
                  game_result    <= 2'd1;
                  tx_en          <= 1'b1;
                  tx_msg_type    <= MSG_STATE_WIN;
               end else if (turn_count == 5'd25) begin
                  state          <= GAME_DRAW;
                  cur_game_state <= GAME_DRAW;
                  game_result    <= 2'd3;
               end else if (p2_last) begin
                  state          <= GAME_WAIT_P1_GUESS;
                  cur_game_state <= GAME_WAIT_P1_GUESS;
                  start_guess    <= 1'b1;
               end else begin
                  state          <= GAME_P2_GUESS;
                  cur_game_state <= GAME_P2_GUESS;
                  start_guess    <= 1'b1;
               end
            end
            GAME_WIN, GAME_LOSE, GAME_DRAW: begin
               if (start_game) begin
                  state          <= GAME_INIT;
                  cur_game_state <= GAME_INIT;
                  clear_guess    <= 1'b1;
               end
            end
            default: begin
               state          <= GAME_IDLE;
               cur_game_state <= GAME_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer_slave.sv
// Randomized self-checking bench for turn_sequencer_slave against a turn-level
// game model (players, turn count, line count computed from line masks).
module tb_turn_sequencer_slave;

   localparam int WIN_LINES = 5;
   localparam int SEL_NUM   = 1;
   localparam int STATE_WIN = 4;
   localparam int ST_IDLE   = 0;
   localparam int ST_INIT   = 1;
   localparam int ST_P1     = 2;
   localparam int ST_P2     = 3;
   localparam int ST_CHECK  = 5;
   localparam int ST_WIN    = 6;
   localparam int ST_LOSE   = 7;
   localparam int ST_DRAW   = 8;

   logic        clk;
   logic        rst;
   logic        interboard_rst;
   logic        start_game;
   logic        interboard_en;
   logic [2:0]  interboard_msg_type;
   logic        guess_done;
   logic [4:0]  guess_number;
   logic [24:0] circle;
   logic [3:0]  cur_game_state;
   logic        start_guess;
   logic        clear_guess;
   logic        tx_en;
   logic [2:0]  tx_msg_type;
   logic [4:0]  tx_number;
   logic [3:0]  line_count;
   logic [4:0]  turn_count;
   logic [1:0]  game_result;

   int checkCount = 0;
   int errorCount = 0;

   int mLines;
   int mTurns;
   int mResult;
   bit mP2;
   int mEndState;

   turn_sequencer_slave #(.WIN_LINES(WIN_LINES), .P1_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .start_game(start_game),
      .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
      .guess_done(guess_done), .guess_number(guess_number), .circle(circle),
      .cur_game_state(cur_game_state), .start_guess(start_guess), .clear_guess(clear_guess),
      .tx_en(tx_en), .tx_msg_type(tx_msg_type), .tx_number(tx_number),
      .line_count(line_count), .turn_count(turn_count), .game_result(game_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A line counts when every position of its mask is circled.
   function automatic int countLines(input logic [24:0] c);
      logic [24:0] m;
      int n;
      n = 0;
      for (int r = 0; r < 5; r++) begin
         m = 25'h1F << (5 * r);
         if ((c & m) == m) n++;
      end
      for (int col = 0; col < 5; col++) begin
         m = '0;
         for (int r = 0; r < 5; r++) m[5*r+col] = 1'b1;
         if ((c & m) == m) n++;
      end
      m = '0;
      for (int k = 0; k < 5; k++) m[6*k] = 1'b1;
      if ((c & m) == m) n++;
      m = '0;
      for (int k = 0; k < 5; k++) m[4*k+4] = 1'b1;
      if ((c & m) == m) n++;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkStatus(input string tag, input int st, input int sg, input int cg,
                              input int txe, input int txt, input int txn,
                              input int ln, input int tn, input int res);
      checkOutput($sformatf("%s_state", tag), 32'(cur_game_state), 32'(st));
      checkOutput($sformatf("%s_start_guess", tag), 32'(start_guess), 32'(sg));
      checkOutput($sformatf("%s_clear_guess", tag), 32'(clear_guess), 32'(cg));
      checkOutput($sformatf("%s_tx_en", tag), 32'(tx_en), 32'(txe));
      checkOutput($sformatf("%s_tx_type", tag), 32'(tx_msg_type), 32'(txt));
      checkOutput($sformatf("%s_tx_number", tag), 32'(tx_number), 32'(txn));
      checkOutput($sformatf("%s_line_count", tag), 32'(line_count), 32'(ln));
      checkOutput($sformatf("%s_turn_count", tag), 32'(turn_count), 32'(tn));
      checkOutput($sformatf("%s_result", tag), 32'(game_result), 32'(res));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startGame();
      start_game = 1'b1;
      tick();
      start_game = 1'b0;
      checkStatus("init", ST_INIT, 0, 1, 0, 0, 0, mLines, mTurns, mResult);
      mLines  = 0;
      mTurns  = 0;
      mResult = 0;
      mP2     = 1'b0;
      tick();
      checkStatus("first_turn", ST_P1, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One turn: idle noise cycles, then a committed guess, then scoring.
   task automatic applyStimulus(input logic [24:0] newCircle, input logic [4:0] num,
                                input int waitCycles, input bit winMsg, output bit gameOver);
      int curState;
      int msg;
      curState = mP2 ? ST_P2 : ST_P1;
      for (int w = 0; w < waitCycles; w++) begin
         msg = int'($urandom_range(0, 7));
         if (!mP2 && msg == STATE_WIN) msg = SEL_NUM;
         interboard_en       = 1'($urandom_range(0, 1));
         interboard_msg_type = 3'(msg);
         start_game          = ($urandom_range(0, 3) == 0);
         tick();
         checkOutput("wait_state", 32'(cur_game_state), 32'(curState));
         checkOutput("wait_start_guess", 32'(start_guess), 32'd0);
         checkOutput("wait_tx_en", 32'(tx_en), 32'd0);
      end
      start_game    = 1'b0;
      interboard_en = 1'b0;
      circle        = newCircle;
      guess_done    = 1'b1;
      guess_number  = num;
      if (winMsg) begin
         interboard_en       = 1'b1;
         interboard_msg_type = 3'(STATE_WIN);
      end
      tick();
      guess_done    = 1'b0;
      interboard_en = 1'b0;
      guess_number  = 5'($urandom_range(0, 31));
      if (winMsg && !mP2) begin
         mResult   = 2;
         mEndState = ST_LOSE;
         checkStatus("lose", ST_LOSE, 0, 0, 0, 0, 0, mLines, mTurns, mResult);
         gameOver = 1'b1;
         return;
      end
      checkStatus("check", ST_CHECK, 0, 0, mP2 ? 1 : 0, mP2 ? SEL_NUM : 0, mP2 ? int'(num) : 0,
                  mLines, mTurns, mResult);
      tick();
      mLines = countLines(newCircle);
      mTurns++;
      checkStatus("decide", ST_CHECK, 0, 0, 0, 0, 0, mLines, mTurns, mResult);
      tick();
      if (mLines >= WIN_LINES) begin
         mResult   = 1;
         mEndState = ST_WIN;
         checkStatus("win", ST_WIN, 0, 0, 1, STATE_WIN, 0, mLines, mTurns, mResult);
         gameOver = 1'b1;
      end else if (mTurns == 25) begin
         mResult   = 3;
         mEndState = ST_DRAW;
         checkStatus("draw", ST_DRAW, 0, 0, 0, 0, 0, mLines, mTurns, mResult);
         gameOver = 1'b1;
      end else begin
         mP2 = !mP2;
         checkStatus("next_turn", mP2 ? ST_P2 : ST_P1, 1, 0, 0, 0, 0, mLines, mTurns, mResult);
         gameOver = 1'b0;
      end
   endtask

   task automatic holdTerminal();
      for (int k = 0; k < 2; k++) begin
         interboard_en       = 1'($urandom_range(0, 1));
         interboard_msg_type = 3'($urandom_range(0, 7));
         tick();
         checkStatus("hold", mEndState, 0, 0, 0, 0, 0, mLines, mTurns, mResult);
      end
      interboard_en = 1'b0;
   endtask

   initial begin
      logic [24:0] winCircle;
      logic [24:0] circ;
      bit over;
      int b;

      rst = 1'b1; interboard_rst = 1'b0; start_game = 1'b0; interboard_en = 1'b0;
      interboard_msg_type = 3'd0; guess_done = 1'b0; guess_number = 5'd0; circle = '0;
      mLines = 0; mTurns = 0; mResult = 0; mP2 = 1'b0; mEndState = ST_IDLE;
      tick();
      tick();
      checkStatus("reset", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      checkStatus("idle", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Directed game: P1, then P2 sends 17, then row 0 plus columns 0-3 wins.
      startGame();
      applyStimulus(25'd0, 5'd3, 1, 1'b0, over);
      applyStimulus(25'd0, 5'd17, 2, 1'b0, over);
      winCircle = 25'h1F;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 4; c++) winCircle[5*r+c] = 1'b1;
      applyStimulus(winCircle, 5'd9, 0, 1'b0, over);
      checkOutput("directed_win_over", 32'(over), 32'd1);
      holdTerminal();

      // Remote win message beats a same-cycle P1 guess.
      startGame();
      applyStimulus(25'h0000_0FF, 5'd4, 1, 1'b1, over);
      holdTerminal();

      // Link reset during P2's turn, racing a start_game pulse.
      startGame();
      applyStimulus(25'd0, 5'd6, 0, 1'b0, over);
      interboard_rst = 1'b1;
      start_game     = 1'b1;
      tick();
      interboard_rst = 1'b0;
      start_game     = 1'b0;
      mLines = 0; mTurns = 0; mResult = 0;
      checkStatus("link_reset", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkStatus("link_reset_idle", ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

      // Empty map for all 25 guesses ends in a draw.
      startGame();
      over = 1'b0;
      for (int t = 0; t < 25 && !over; t++)
         applyStimulus(25'd0, 5'($urandom_range(1, 25)), int'($urandom_range(0, 2)), 1'b0, over);
      checkOutput("draw_turns", 32'(turn_count), 32'd25);
      holdTerminal();

      // Random games with a growing circle map and occasional remote wins.
      for (int g = 0; g < 8; g++) begin
         startGame();
         circ = '0;
         over = 1'b0;
         while (!over) begin
            do b = int'($urandom_range(0, 24)); while (circ[b]);
            circ[b] = 1'b1;
            applyStimulus(circ, 5'(b + 1), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 14) == 0), over);
         end
         holdTerminal();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
